// File: rtl/map_bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : map_bram_arbiter
// Description : Shares one map BROM between NUM_REQ DDA requesters. Each
//               requester may hold one outstanding read. Requests are granted
//               round-robin, at most one per cycle. The returned cell is
//               broadcast on map_data_out, and a one-hot map_valid_out pulse
//               names the requester that owns it.
// Revision    : 1.0 - initial release
// ============================================================================
module map_bram_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 5,
    parameter int BRAM_LATENCY = 2
) (
    input  logic                      pixel_clk_in,
    input  logic                      rst_n_in,
    input  logic [NUM_REQ-1:0]        req_in,
    input  logic [NUM_REQ*ADDR_W-1:0] addr_in,
    input  logic                      flush_in,
    output logic [ADDR_W-1:0]         bram_addr_out,
    output logic                      bram_en_out,
    input  logic [DATA_W-1:0]         bram_data_in,
    output logic [DATA_W-1:0]         map_data_out,
    output logic [NUM_REQ-1:0]        map_valid_out,
    output logic [NUM_REQ-1:0]        err_out
);

    localparam int c_ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // Stage 0 lines up with the registered BROM address; the read data can be
    // sampled while the id sits in the last stage, giving BRAM_LATENCY+1 stages.
    localparam int c_DEPTH = BRAM_LATENCY + 1;
    localparam int c_LAST  = c_DEPTH - 1;
    localparam logic [c_ID_W-1:0] c_LAST_GRANT_RST = c_ID_W'(NUM_REQ - 1);

    // Per-requester request state
    logic [NUM_REQ-1:0] r_pending;
    logic [ADDR_W-1:0]  r_addr [NUM_REQ];
    logic [c_ID_W-1:0]  r_last_grant;

    // In-flight read tracking
    logic [c_DEPTH-1:0] r_fl_vld;
    logic [c_ID_W-1:0]  r_fl_id [c_DEPTH];

    // Combinational decisions
    logic               w_grant_vld;
    logic [c_ID_W-1:0]  w_grant_id;
    logic [c_ID_W-1:0]  w_idx;
    logic               w_issue;
    logic [NUM_REQ-1:0] w_grant_mask;
    logic [NUM_REQ-1:0] w_busy;
    logic [NUM_REQ-1:0] w_accept;
    logic [NUM_REQ-1:0] w_viol;
    logic               w_emerge;
    logic [NUM_REQ-1:0] w_ret_mask;

    // Round-robin search starting one past the last granted requester.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_id  = '0;
        w_idx       = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_idx = c_ID_W'((int'(r_last_grant) + off) % NUM_REQ);
            if (!w_grant_vld && r_pending[w_idx]) begin
                w_grant_vld = 1'b1;
                w_grant_id  = w_idx;
            end
        end
    end

    // A flush cancels any grant on the same edge.
    assign w_issue = w_grant_vld & ~flush_in;

    // One-hot form of the grant, used to clear the granted pending flag.
    always_comb begin
        w_grant_mask = '0;
        if (w_issue) begin
            w_grant_mask[w_grant_id] = 1'b1;
        end
    end

    // A requester is busy while pending or while its read is in flight. The
    // final stage is excluded: that read returns on this edge, so a new request
    // arriving on the same edge is legal.
    always_comb begin
        w_busy = r_pending;
        for (int i = 0; i < NUM_REQ; i++) begin
            for (int s = 0; s < c_LAST; s++) begin
                if (r_fl_vld[s] && (r_fl_id[s] == c_ID_W'(i))) begin
                    w_busy[i] = 1'b1;
                end
            end
        end
    end

    // Requests on a flush edge are dropped entirely, without flagging errors.
    assign w_accept = req_in & ~w_busy & {NUM_REQ{~flush_in}};
    assign w_viol   = req_in &  w_busy & {NUM_REQ{~flush_in}};

    // Pending flags: set on an accepted request, cleared on grant, wiped by flush.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_pending <= '0;
        end else if (flush_in) begin
            r_pending <= '0;
        end else begin
            r_pending <= (r_pending & ~w_grant_mask) | w_accept;
        end
    end

    // Capture each requester's address with its accepted request.
    always_ff @(posedge pixel_clk_in) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_accept[i]) begin
                r_addr[i] <= addr_in[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Drive the BROM port; the address holds between grants.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bram_en_out   <= 1'b0;
            bram_addr_out <= '0;
            r_last_grant  <= c_LAST_GRANT_RST;
        end else begin
            bram_en_out <= w_issue;
            if (w_issue) begin
                bram_addr_out <= r_addr[w_grant_id];
                r_last_grant  <= w_grant_id;
            end
        end
    end

    // Valid bits of the in-flight pipeline; flush and reset drop every read.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_fl_vld <= '0;
        end else if (flush_in) begin
            r_fl_vld <= '0;
        end else begin
            r_fl_vld <= {r_fl_vld[c_DEPTH-2:0], w_issue};
        end
    end

    // Requester ids travel alongside the valid bits and are only read when valid.
    always_ff @(posedge pixel_clk_in) begin
        r_fl_id[0] <= w_grant_id;
        for (int s = 1; s < c_DEPTH; s++) begin
            r_fl_id[s] <= r_fl_id[s-1];
        end
    end

    assign w_emerge = r_fl_vld[c_LAST] & ~flush_in;

    // One-hot owner of the read that is leaving the pipeline.
    always_comb begin
        w_ret_mask = '0;
        w_ret_mask[r_fl_id[c_LAST]] = 1'b1;
    end

    // Register the returned cell and pulse the owner's valid for one cycle.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            map_valid_out <= '0;
            map_data_out  <= '0;
        end else begin
            map_valid_out <= '0;
            if (w_emerge) begin
                map_valid_out <= w_ret_mask;
                map_data_out  <= bram_data_in;
            end
        end
    end

    // Sticky protocol-violation flags; only reset clears them.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            err_out <= '0;
        end else begin
            err_out <= err_out | w_viol;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_map_bram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_map_bram_arbiter
// Description : Self-checking bench for map_bram_arbiter against a
//               transaction-level reference model (request flags, a queue of
//               outstanding reads with due cycles, and a BROM content array).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_map_bram_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int ADDR_W   = 10;
    localparam int DATA_W   = 5;
    localparam int LAT      = 2;
    localparam int ROM_SIZE = 1 << ADDR_W;

    logic                      clk = 1'b0;
    logic                      rst_n;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] addr;
    logic                      flush;
    logic [ADDR_W-1:0]         bram_addr;
    logic                      bram_en;
    logic [DATA_W-1:0]         bram_data;
    logic [DATA_W-1:0]         map_data;
    logic [NUM_REQ-1:0]        map_valid;
    logic [NUM_REQ-1:0]        err;

    always #5 clk = ~clk;

    map_bram_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .BRAM_LATENCY(LAT)
    ) dut (
        .pixel_clk_in (clk),
        .rst_n_in     (rst_n),
        .req_in       (req),
        .addr_in      (addr),
        .flush_in     (flush),
        .bram_addr_out(bram_addr),
        .bram_en_out  (bram_en),
        .bram_data_in (bram_data),
        .map_data_out (map_data),
        .map_valid_out(map_valid),
        .err_out      (err)
    );

    // BROM: contents plus a LAT-stage read pipeline.
    logic [DATA_W-1:0] rom      [ROM_SIZE];
    logic [DATA_W-1:0] rom_pipe [LAT];

    always @(posedge clk) begin
        rom_pipe[0] <= rom[bram_addr];
        for (int k = 1; k < LAT; k++) rom_pipe[k] <= rom_pipe[k-1];
    end
    assign bram_data = rom_pipe[LAT-1];

    // Reference model state
    typedef struct {
        int id;
        int a;
        int due;
    } flight_t;

    flight_t            q[$];
    bit                 m_pending [NUM_REQ];
    int                 m_addr    [NUM_REQ];
    int                 m_last;
    int                 m_cyc;
    logic               m_en;
    logic [ADDR_W-1:0]  m_baddr;
    logic [NUM_REQ-1:0] m_valid;
    logic [NUM_REQ-1:0] m_err;
    logic [DATA_W-1:0]  m_data;

    int total = 0;
    int bad   = 0;
    int vcount [NUM_REQ];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < NUM_REQ; i++) begin
            m_pending[i] = 1'b0;
            m_addr[i]    = 0;
        end
        m_last  = NUM_REQ - 1;
        m_cyc   = 0;
        m_en    = 1'b0;
        m_baddr = '0;
        m_valid = '0;
        m_err   = '0;
        m_data  = '0;
    endtask

    // One clock edge of the reference behaviour, using the inputs presented.
    task automatic model_edge();
        bit busy [NUM_REQ];
        int emerge = -1;
        int g      = -1;
        int c;
        m_cyc++;
        for (int k = 0; k < q.size(); k++) if (q[k].due == m_cyc) emerge = k;
        for (int i = 0; i < NUM_REQ; i++) begin
            busy[i] = m_pending[i];
            for (int k = 0; k < q.size(); k++) if (k != emerge && q[k].id == i) busy[i] = 1'b1;
        end
        if (flush) begin
            for (int i = 0; i < NUM_REQ; i++) m_pending[i] = 1'b0;
            q.delete();
            m_valid = '0;
            m_en    = 1'b0;
            return;
        end
        m_valid = '0;
        if (emerge >= 0) begin
            m_valid[q[emerge].id] = 1'b1;
            m_data = rom[q[emerge].a];
            q.delete(emerge);
        end
        for (int off = 1; off <= NUM_REQ; off++) begin
            c = (m_last + off) % NUM_REQ;
            if (g < 0 && m_pending[c]) g = c;
        end
        m_en = 1'b0;
        if (g >= 0) begin
            m_en         = 1'b1;
            m_baddr      = ADDR_W'(m_addr[g]);
            m_pending[g] = 1'b0;
            m_last       = g;
            q.push_back('{id: g, a: m_addr[g], due: m_cyc + LAT + 1});
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req[i]) begin
                if (busy[i]) m_err[i] = 1'b1;
                else begin
                    m_pending[i] = 1'b1;
                    m_addr[i]    = int'(addr[i*ADDR_W +: ADDR_W]);
                end
            end
        end
    endtask

    task automatic check_all(input string where);
        chk({where, ":bram_en"},   bram_en,   m_en);
        chk({where, ":bram_addr"}, bram_addr, m_baddr);
        chk({where, ":map_valid"}, map_valid, m_valid);
        chk({where, ":map_data"},  map_data,  m_data);
        chk({where, ":err"},       err,       m_err);
    endtask

    function automatic logic [NUM_REQ*ADDR_W-1:0] rand_addr();
        logic [NUM_REQ*ADDR_W-1:0] v;
        for (int i = 0; i < NUM_REQ; i++) v[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom_range(ROM_SIZE - 1));
        return v;
    endfunction

    task automatic step(input logic [NUM_REQ-1:0] r, input logic [NUM_REQ*ADDR_W-1:0] a, input logic fl);
        @(negedge clk);
        req   = r;
        addr  = a;
        flush = fl;
        @(posedge clk);
        model_edge();
        #1;
        check_all("cycle");
        for (int i = 0; i < NUM_REQ; i++) if (map_valid[i]) vcount[i]++;
    endtask

    task automatic idle(input int n);
        repeat (n) step('0, rand_addr(), 1'b0);
    endtask

    task automatic clear_counts();
        for (int i = 0; i < NUM_REQ; i++) vcount[i] = 0;
    endtask

    // Assert reset between edges and check that outputs clear without a clock.
    task automatic do_reset();
        @(negedge clk);
        req   = '0;
        flush = 1'b0;
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all("async_rst");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NUM_REQ*ADDR_W-1:0] a;
        logic [NUM_REQ*ADDR_W-1:0] fa;
        logic [NUM_REQ-1:0]        r;
        logic                      fl;
        int                        req_t [NUM_REQ];
        int                        prev_g;
        int                        g;

        rst_n = 1'b0;
        req   = '0;
        addr  = '0;
        flush = 1'b0;
        for (int k = 0; k < ROM_SIZE; k++) rom[k] = DATA_W'($urandom);
        rom[37] = 5'd3;
        model_reset();
        clear_counts();
        repeat (3) @(posedge clk);
        #1 check_all("reset");
        @(negedge clk) rst_n = 1'b1;

        // Single request latency, plus a new request on the valid edge.
        a = rand_addr();
        a[0 +: ADDR_W] = 10'd37;
        step(4'b0001, a, 1'b0);
        chk("lat_en_e0", bram_en, 1'b0);
        idle(1);
        chk("lat_addr_e1", bram_addr, 10'd37);
        chk("lat_en_e1", bram_en, 1'b1);
        idle(2);
        chk("lat_valid_e3", map_valid, 4'b0000);
        a[0 +: ADDR_W] = 10'd38;
        step(4'b0001, a, 1'b0);
        chk("lat_valid_e4", map_valid, 4'b0001);
        chk("lat_data_e4", map_data, 5'd3);
        chk("same_edge_err", err, 4'b0000);
        idle(6);
        chk("lat_count", vcount[0], 2);

        // Simultaneous requests after reset: grants 0,1,2,3 back to back.
        do_reset();
        clear_counts();
        a = rand_addr();
        step(4'b1111, a, 1'b0);
        for (int i = 0; i < NUM_REQ; i++) begin
            idle(1);
            chk("rr_en", bram_en, 1'b1);
            chk("rr_addr", bram_addr, a[i*ADDR_W +: ADDR_W]);
        end
        idle(6);
        for (int i = 0; i < NUM_REQ; i++) chk("rr_count", vcount[i], 1);

        // Fairness: requesters 0 and 2 re-request on every valid.
        fa = '0;
        fa[0 +: ADDR_W]        = 10'd100;
        fa[2*ADDR_W +: ADDR_W] = 10'd200;
        r      = 4'b0101;
        prev_g = -1;
        for (int i = 0; i < NUM_REQ; i++) req_t[i] = 0;
        for (int t = 0; t < 20; t++) begin
            for (int i = 0; i < NUM_REQ; i++) if (r[i]) req_t[i] = t;
            step(r, fa, 1'b0);
            if (bram_en) begin
                g = (bram_addr == 10'd100) ? 0 : 2;
                if (prev_g >= 0) chk("fair_alt", g != prev_g, 1'b1);
                chk("fair_wait", (t - req_t[g]) <= NUM_REQ, 1'b1);
                prev_g = g;
            end
            r = map_valid & 4'b0101;
        end
        idle(8);

        // Violation: requester 1 asks again while its read is in flight.
        clear_counts();
        step(4'b0010, rand_addr(), 1'b0);
        idle(1);
        step(4'b0010, rand_addr(), 1'b0);
        chk("viol_err", err[1], 1'b1);
        idle(6);
        chk("viol_err_sticky", err[1], 1'b1);
        chk("viol_count", vcount[1], 1);

        // Flush one cycle after granting requester 2.
        clear_counts();
        step(4'b0100, rand_addr(), 1'b0);
        idle(1);
        step('0, rand_addr(), 1'b1);
        idle(6);
        chk("flush_drop", vcount[2], 0);
        chk("flush_err_kept", err[1], 1'b1);
        step(4'b0100, rand_addr(), 1'b0);
        idle(6);
        chk("flush_next", vcount[2], 1);

        // Reset one cycle after granting requester 2.
        clear_counts();
        step(4'b0100, rand_addr(), 1'b0);
        idle(1);
        do_reset();
        idle(6);
        chk("rst_drop", vcount[2], 0);
        chk("rst_err_clr", err, 4'b0000);
        step(4'b0100, rand_addr(), 1'b0);
        idle(6);
        chk("rst_next", vcount[2], 1);

        // Randomized traffic with occasional flushes and one mid-run reset.
        for (int t = 0; t < 400; t++) begin
            r  = NUM_REQ'($urandom) & NUM_REQ'($urandom);
            fl = ($urandom_range(31) == 0);
            step(r, rand_addr(), fl);
            if (t == 200) do_reset();
        end
        idle(8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
